vga_sync: RTL

Generates 640x480@60 Hz VGA timing from the 100 MHz Basys 3 clock.
- Produces the pixel coordinates x/y consumed by the ball, paddle and score renderers.
- Produces a once-per-frame tick for game-state update logic.
- Produces hsync/vsync for the VGA connector.
- It is the producer side of the x/y pixel-scan interface that all drawing blocks read.

---
 rtl/vga_timing_pkg.sv | 29 ++
 rtl/vga_sync_pixel_tick_gen.sv | 29 ++
 rtl/vga_sync.sv | 82 ++++++++
 3 files changed

// File: rtl/vga_timing_pkg.sv
// 640x480@60 VGA timing constants shared by the sync generator and the game renderers.
package vga_timing_pkg;

  localparam int CLK_DIV   = 4;
  localparam int H_DISPLAY = 640;
  localparam int H_FRONT   = 16;
  localparam int H_SYNC    = 96;
  localparam int H_BACK    = 48;
  localparam int H_TOTAL   = H_DISPLAY + H_FRONT + H_SYNC + H_BACK;
  localparam int V_DISPLAY = 480;
  localparam int V_FRONT   = 10;
  localparam int V_SYNC    = 2;
  localparam int V_BACK    = 33;
  localparam int V_TOTAL   = V_DISPLAY + V_FRONT + V_SYNC + V_BACK;
  localparam int TICK_LINE = 481;

  localparam int H_SYNC_START = H_DISPLAY + H_FRONT;
  localparam int H_SYNC_END   = H_SYNC_START + H_SYNC - 1;
  localparam int V_SYNC_START = V_DISPLAY + V_FRONT;
  localparam int V_SYNC_END   = V_SYNC_START + V_SYNC - 1;

  localparam int SCREEN_X_MAX = H_DISPLAY - 1;
  localparam int SCREEN_Y_MAX = V_DISPLAY - 1;

  function automatic logic in_range(logic [9:0] v, logic [9:0] lo, logic [9:0] hi);
    return (v >= lo) && (v <= hi);
  endfunction

endpackage

// File: rtl/vga_sync_pixel_tick_gen.sv
// Mod-CLK_DIV divider producing a registered one-clk pixel-advance pulse.
module pixel_tick_gen #(
  parameter int CLK_DIV = 4
) (
  input  logic clk,
  input  logic reset_n,
  output logic p_tick
);
  localparam int DW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [DW-1:0] DIV_MAX = DW'(CLK_DIV - 1);

  logic [DW-1:0] div_q, div_d;
  logic          p_tick_q;

  assign div_d  = (div_q == DIV_MAX) ? '0 : div_q + 1'b1;
  assign p_tick = p_tick_q;

  // The pulse is the registered terminal count, so it lands on the clk the divider wraps.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      div_q    <= '0;
      p_tick_q <= 1'b0;
    end else begin
      div_q    <= div_d;
      p_tick_q <= (div_q == DIV_MAX);
    end
  end

endmodule

// File: rtl/vga_sync.sv
// VGA scan generator: pixel counters, registered syncs and a once-per-frame tick.
import vga_timing_pkg::*;

module vga_sync #(
  parameter int CLK_DIV   = vga_timing_pkg::CLK_DIV,
  parameter int H_DISPLAY = vga_timing_pkg::H_DISPLAY,
  parameter int H_FRONT   = vga_timing_pkg::H_FRONT,
  parameter int H_SYNC    = vga_timing_pkg::H_SYNC,
  parameter int H_BACK    = vga_timing_pkg::H_BACK,
  parameter int V_DISPLAY = vga_timing_pkg::V_DISPLAY,
  parameter int V_FRONT   = vga_timing_pkg::V_FRONT,
  parameter int V_SYNC    = vga_timing_pkg::V_SYNC,
  parameter int V_BACK    = vga_timing_pkg::V_BACK,
  parameter int TICK_LINE = vga_timing_pkg::TICK_LINE
) (
  input  logic       clk,
  input  logic       reset_n,
  output logic       p_tick,
  output logic [9:0] x,
  output logic [9:0] y,
  output logic       video_on,
  output logic       hsync,
  output logic       vsync,
  output logic       frame_tick
);
  localparam logic [9:0] X_MAX    = 10'(H_DISPLAY + H_FRONT + H_SYNC + H_BACK - 1);
  localparam logic [9:0] Y_MAX    = 10'(V_DISPLAY + V_FRONT + V_SYNC + V_BACK - 1);
  localparam logic [9:0] HS_START = 10'(H_DISPLAY + H_FRONT);
  localparam logic [9:0] HS_END   = 10'(H_DISPLAY + H_FRONT + H_SYNC - 1);
  localparam logic [9:0] VS_START = 10'(V_DISPLAY + V_FRONT);
  localparam logic [9:0] VS_END   = 10'(V_DISPLAY + V_FRONT + V_SYNC - 1);
  localparam logic [9:0] X_VIS    = 10'(H_DISPLAY);
  localparam logic [9:0] Y_VIS    = 10'(V_DISPLAY);
  localparam logic [9:0] Y_TICK   = 10'(TICK_LINE);

  logic [9:0] x_q, x_d, y_q, y_d;
  logic       hsync_q, vsync_q, frame_tick_q;

  pixel_tick_gen #(.CLK_DIV(CLK_DIV)) u_tick (
    .clk    (clk),
    .reset_n(reset_n),
    .p_tick (p_tick)
  );

  always_comb begin
    x_d = x_q;
    y_d = y_q;
    if (p_tick) begin
      if (x_q == X_MAX) begin
        x_d = '0;
        y_d = (y_q == Y_MAX) ? '0 : y_q + 10'd1;
      end else begin
        x_d = x_q + 10'd1;
      end
    end
  end

  // Syncs and tick decode the next-state counts so they move on the same clk as x/y.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      x_q          <= '0;
      y_q          <= '0;
      hsync_q      <= 1'b1;
      vsync_q      <= 1'b1;
      frame_tick_q <= 1'b0;
    end else begin
      x_q          <= x_d;
      y_q          <= y_d;
      hsync_q      <= !in_range(x_d, HS_START, HS_END);
      vsync_q      <= !in_range(y_d, VS_START, VS_END);
      frame_tick_q <= p_tick && (x_d == '0) && (y_d == Y_TICK);
    end
  end

  assign x          = x_q;
  assign y          = y_q;
  assign hsync      = hsync_q;
  assign vsync      = vsync_q;
  assign frame_tick = frame_tick_q;
  assign video_on   = (x_q < X_VIS) && (y_q < Y_VIS);

endmodule
